// File: rtl/proc_param_if.sv
// Bus between proc_param and its memory/controller: start request, memory
// handshake, and the per-instruction Done pulse.
interface proc_param_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              Run;
    logic [DATA_W-1:0] DIN;
    logic              Ack;
    logic              Req;
    logic              W;
    logic [ADDR_W-1:0] ADDR;
    logic [DATA_W-1:0] DOUT;
    logic              Done;

    modport slave (
        input  Run, DIN, Ack,
        output Req, W, ADDR, DOUT, Done
    );

    modport master (
        output Run, DIN, Ack,
        input  Req, W, ADDR, DOUT, Done
    );
endinterface

// File: rtl/proc_param.sv
// Multi-cycle 8-register processor with a Req/Ack memory port.
// Optional feature: define PROC_BL_EN to turn branch cond 111 into bl (R6 <= PC).
module proc_param #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic        Clock,
    input  logic        Reset,
    proc_param_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EX1   = 3'd2,
        S_EX2   = 3'd3,
        S_EX3   = 3'd4,
        S_MEM   = 3'd5
    } state_t;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVT = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_LD  = 3'b100;
    localparam logic [2:0] OP_ST  = 3'b101;
    localparam logic [2:0] OP_AND = 3'b110;
    localparam logic [2:0] OP_B   = 3'b111;

    localparam logic [DATA_W-1:0] ZERO = {DATA_W{1'b0}};
    localparam logic [DATA_W-1:0] ONE  = {{(DATA_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    logic [DATA_W-1:0] r_reg [8];
    logic [15:0]       r_ir;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_g;
    logic              r_z;
    logic              r_n;
    logic              r_c;
    logic              r_req;
    logic              r_w;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_dout;
    logic              r_done;

    logic [2:0]        w_op;
    logic              w_m;
    logic [2:0]        w_rx;
    logic [2:0]        w_ry;
    logic [8:0]        w_d;
    logic              w_ack;
    logic [DATA_W-1:0] w_operand;
    logic [DATA_W-1:0] w_pc_br;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_res;
    logic              w_cout;

    function automatic logic [DATA_W-1:0] sext9(input logic [8:0] d);
        return {{(DATA_W-9){d[8]}}, d};
    endfunction

    // Cond 111 is not a condition; bl handling (when built in) is separate.
    function automatic logic cond_met(input logic [2:0] cond, input logic z,
                                      input logic n, input logic c);
        logic met;
        case (cond)
            3'b000:  met = 1'b1;
            3'b001:  met = z;
            3'b010:  met = ~z;
            3'b011:  met = ~c;
            3'b100:  met = c;
            3'b101:  met = ~n;
            3'b110:  met = n;
            default: met = 1'b0;
        endcase
        return met;
    endfunction

    assign w_op      = r_ir[15:13];
    assign w_m       = r_ir[12];
    assign w_rx      = r_ir[11:9];
    assign w_d       = r_ir[8:0];
    assign w_ry      = r_ir[2:0];
    assign w_ack     = bus.Ack & r_req;
    assign w_operand = w_m ? {{(DATA_W-9){1'b0}}, w_d} : r_reg[w_ry];
    assign w_pc_br   = r_reg[7] + sext9(w_d);

    // ALU result and carry/borrow for the EX2 step
    always_comb begin
        w_sum  = {1'b0, r_a} + {1'b0, w_operand};
        w_res  = ZERO;
        w_cout = 1'b0;
        case (w_op)
            OP_ADD: begin
                w_res  = w_sum[DATA_W-1:0];
                w_cout = w_sum[DATA_W];
            end
            OP_SUB: begin
                w_res  = r_a - w_operand;
                w_cout = (r_a < w_operand);
            end
            OP_AND: begin
                w_res  = r_a & w_operand;
                w_cout = 1'b0;
            end
            default: begin
                w_res  = ZERO;
                w_cout = 1'b0;
            end
        endcase
    end

    // Control FSM, register file, flags and registered bus outputs
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= S_IDLE;
            for (int i = 0; i < 8; i++) begin
                r_reg[i] <= ZERO;
            end
            r_ir   <= 16'h0000;
            r_a    <= ZERO;
            r_g    <= ZERO;
            r_z    <= 1'b0;
            r_n    <= 1'b0;
            r_c    <= 1'b0;
            r_req  <= 1'b0;
            r_w    <= 1'b0;
            r_addr <= {ADDR_W{1'b0}};
            r_dout <= ZERO;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.Run) begin
                        r_addr   <= r_reg[7][ADDR_W-1:0];
                        r_req    <= 1'b1;
                        r_w      <= 1'b0;
                        r_reg[7] <= r_reg[7] + ONE;
                        r_state  <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (w_ack) begin
                        r_ir    <= bus.DIN[15:0];
                        r_req   <= 1'b0;
                        r_state <= S_EX1;
                    end
                end
                S_EX1: begin
                    case (w_op)
                        OP_MV: begin
                            r_reg[w_rx] <= w_operand;
                            r_done      <= 1'b1;
                            r_state     <= S_IDLE;
                        end
                        OP_MVT: begin
                            r_reg[w_rx] <= {w_d[7:0], {(DATA_W-8){1'b0}}};
                            r_done      <= 1'b1;
                            r_state     <= S_IDLE;
                        end
                        OP_ADD, OP_SUB, OP_AND: begin
                            r_a     <= r_reg[w_rx];
                            r_state <= S_EX2;
                        end
                        OP_LD, OP_ST: begin
                            r_addr  <= r_reg[w_ry][ADDR_W-1:0];
                            r_req   <= 1'b1;
                            r_w     <= (w_op == OP_ST);
                            r_dout  <= r_reg[w_rx];
                            r_state <= S_MEM;
                        end
                        OP_B: begin
`ifdef PROC_BL_EN
                            if (w_rx == 3'b111) begin
                                r_reg[6] <= r_reg[7];
                                r_reg[7] <= w_pc_br;
                            end else if (cond_met(w_rx, r_z, r_n, r_c)) begin
                                r_reg[7] <= w_pc_br;
                            end
`else
                            if (cond_met(w_rx, r_z, r_n, r_c)) begin
                                r_reg[7] <= w_pc_br;
                            end
`endif
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end
                        default: r_state <= S_IDLE;
                    endcase
                end
                S_EX2: begin
                    r_g     <= w_res;
                    r_z     <= (w_res == ZERO);
                    r_n     <= w_res[DATA_W-1];
                    r_c     <= w_cout;
                    r_state <= S_EX3;
                end
                S_EX3: begin
                    r_reg[w_rx] <= r_g;
                    r_done      <= 1'b1;
                    r_state     <= S_IDLE;
                end
                S_MEM: begin
                    if (w_ack) begin
                        if (w_op == OP_LD) begin
                            r_reg[w_rx] <= bus.DIN;
                        end
                        r_req   <= 1'b0;
                        r_w     <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.Req  = r_req;
    assign bus.W    = r_w;
    assign bus.ADDR = r_addr;
    assign bus.DOUT = r_dout;
    assign bus.Done = r_done;

endmodule

// File: tb/tb_proc_param.sv
// Directed self-checking bench for proc_param; expectations follow the
// PROC_BL_EN setting of the build.
module tb_proc_param;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    int          lat;
    int          mreq;
    logic [15:0] faddr;
    logic [15:0] maddr;
    logic [15:0] mdout;
    logic        mw;
    logic        held;
    logic [15:0] exp_r6;
    logic [15:0] exp_pc;

    proc_param_if #(.DATA_W(16), .ADDR_W(16)) bus ();

    proc_param #(.DATA_W(16), .ADDR_W(16)) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        bus.Run = 1'b0;
        bus.Ack = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Runs one instruction, acting as the memory; fd/md are extra Ack wait cycles.
    task automatic exec(input logic [15:0] ir, input int fd, input int md,
                        input logic [15:0] rdata);
        int   fw;
        int   mwc;
        logic fdone;
        logic done;
        fw = 0; mwc = 0; fdone = 1'b0; done = 1'b0;
        lat = 0; mreq = 0; held = 1'b1;
        faddr = 16'h0000; maddr = 16'h0000; mdout = 16'h0000; mw = 1'b0;
        @(negedge clk);
        bus.Run = 1'b1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            bus.Run = 1'b0;
            bus.Ack = 1'b0;
            if (bus.Done) begin
                done = 1'b1;
            end else if (bus.Req && !fdone) begin
                faddr = bus.ADDR;
                if (fw == fd) begin
                    bus.Ack = 1'b1;
                    bus.DIN = ir;
                    fdone   = 1'b1;
                end else begin
                    fw++;
                end
            end else if (bus.Req) begin
                if (mreq == 0) begin
                    maddr = bus.ADDR;
                    mdout = bus.DOUT;
                    mw    = bus.W;
                end else if (bus.ADDR !== maddr || bus.DOUT !== mdout || bus.W !== mw) begin
                    held = 1'b0;
                end
                mreq++;
                if (mwc == md) begin
                    bus.Ack = 1'b1;
                    bus.DIN = rdata;
                end else begin
                    mwc++;
                end
            end
        end
    endtask

    task automatic run(input string tag, input logic [15:0] ir, input int exp_lat);
        exec(ir, 0, 0, 16'h0000);
        check_eq(tag, lat, exp_lat);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        bus.Run  = 1'b0;
        bus.Ack  = 1'b0;
        bus.DIN  = 16'h0000;
        do_reset();

        check_eq("rst_req",  bus.Req,  1'b0);
        check_eq("rst_w",    bus.W,    1'b0);
        check_eq("rst_done", bus.Done, 1'b0);
        check_eq("rst_addr", bus.ADDR, 16'h0000);
        check_eq("rst_dout", bus.DOUT, 16'h0000);
        check_eq("rst_pc",   dut.r_reg[7], 16'h0000);

        // mv R1,#5
        run("mv_lat", 16'h1205, 3);
        check_eq("mv_faddr", faddr, 16'h0000);
        check_eq("mv_r1", dut.r_reg[1], 16'h0005);
        check_eq("mv_pc", dut.r_reg[7], 16'h0001);
        @(negedge clk);
        check_eq("done_one_cycle", bus.Done, 1'b0);

        // R2 = 0xFFFF, then add R2,#1 wraps to zero
        run("mvt_lat", 16'h34FF, 3);
        check_eq("mvt_r2", dut.r_reg[2], 16'hFF00);
        run("add_lat", 16'h54FF, 5);
        check_eq("add_r2", dut.r_reg[2], 16'hFFFF);
        check_eq("add_n", dut.r_n, 1'b1);
        run("add_wrap_lat", 16'h5401, 5);
        check_eq("add_wrap_r2", dut.r_reg[2], 16'h0000);
        check_eq("add_wrap_z", dut.r_z, 1'b1);
        check_eq("add_wrap_c", dut.r_c, 1'b1);
        check_eq("add_wrap_n", dut.r_n, 1'b0);

        // bne not taken, beq D=-2 taken at PC=5
        run("bne_lat", 16'hE403, 3);
        check_eq("bne_pc", dut.r_reg[7], 16'h0005);
        run("beq_lat", 16'hE3FE, 3);
        check_eq("beq_pc", dut.r_reg[7], 16'h0004);

        // st R3,[R4] with three Ack wait cycles
        run("mvt_r3", 16'h36AB, 3);
        run("add_r3", 16'h56CD, 5);
        run("mv_r4",  16'h1810, 3);
        exec(16'hA604, 0, 3, 16'h0000);
        check_eq("st_lat",  lat,  7);
        check_eq("st_mreq", mreq, 4);
        check_eq("st_addr", maddr, 16'h0010);
        check_eq("st_dout", mdout, 16'hABCD);
        check_eq("st_w",    mw,    1'b1);
        check_eq("st_held", held,  1'b1);

        // ld R5,[R4]
        exec(16'h8A04, 0, 0, 16'h1234);
        check_eq("ld_lat", lat, 4);
        check_eq("ld_w",   mw,  1'b0);
        check_eq("ld_r5",  dut.r_reg[5], 16'h1234);

        // sub register / immediate with borrow, and
        run("sub_lat", 16'h6A01, 5);
        check_eq("sub_r5", dut.r_reg[5], 16'h122F);
        check_eq("sub_c",  dut.r_c, 1'b0);
        run("subb_lat", 16'h7206, 5);
        check_eq("subb_r1", dut.r_reg[1], 16'hFFFF);
        check_eq("subb_c",  dut.r_c, 1'b1);
        check_eq("subb_n",  dut.r_n, 1'b1);
        run("and_lat", 16'hDAF0, 5);
        check_eq("and_r5", dut.r_reg[5], 16'h0020);
        check_eq("and_c",  dut.r_c, 1'b0);

        // Fetch Ack delayed by two cycles
        exec(16'h1007, 2, 0, 16'h0000);
        check_eq("fwait_lat", lat, 5);
        check_eq("fwait_r0", dut.r_reg[0], 16'h0007);

        // bl / cond 111 at PC=2
        do_reset();
        run("mv_r6", 16'h1C55, 3);
        run("mv_r7_jump", 16'h1E02, 3);
        check_eq("jump_pc", dut.r_reg[7], 16'h0002);
`ifdef PROC_BL_EN
        exp_r6 = 16'h0003;
        exp_pc = 16'h0007;
`else
        exp_r6 = 16'h0055;
        exp_pc = 16'h0003;
`endif
        run("bl_lat", 16'hEE04, 3);
        check_eq("bl_r6", dut.r_reg[6], exp_r6);
        check_eq("bl_pc", dut.r_reg[7], exp_pc);

        // PC wrap from 0xFFFF
        run("wrap_mvt", 16'h30FF, 3);
        run("wrap_add", 16'h50FF, 5);
        run("wrap_mv_pc", 16'h0E00, 3);
        check_eq("wrap_pc_set", dut.r_reg[7], 16'hFFFF);
        run("wrap_fetch", 16'h1000, 3);
        check_eq("wrap_faddr", faddr, 16'hFFFF);
        check_eq("wrap_pc", dut.r_reg[7], 16'h0000);

        // Reset while ld R1,[R0] waits in MEM; Ack arrives after the abort
        run("mv_r1_9", 16'h1209, 3);
        @(negedge clk);
        bus.Run = 1'b1;
        @(negedge clk);
        bus.Run = 1'b0;
        bus.Ack = 1'b1;
        bus.DIN = 16'h8200;
        @(negedge clk);
        bus.Ack = 1'b0;
        @(negedge clk);
        check_eq("abort_in_mem", bus.Req, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort_req", bus.Req, 1'b0);
        check_eq("abort_w",   bus.W,   1'b0);
        @(negedge clk);
        bus.Ack = 1'b1;
        bus.DIN = 16'hBEEF;
        @(negedge clk);
        @(negedge clk);
        bus.Ack = 1'b0;
        check_eq("abort_r1",    dut.r_reg[1], 16'h0000);
        check_eq("abort_state", dut.r_state, 3'd0);
        check_eq("abort_idle_req", bus.Req, 1'b0);
        check_eq("abort_done", bus.Done, 1'b0);
        run("post_abort_lat", 16'h1403, 3);
        check_eq("post_abort_r2", dut.r_reg[2], 16'h0003);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/proc_param.md
PROC_PARAM -- requirements
Module: proc_param

Interface
REQ-001 Parameter DATA_W, 16, datapath/register width; legal values 16..32.
REQ-002 Parameter ADDR_W, 16, memory address width; ADDR_W SHALL be <= DATA_W.
REQ-003 Clock  input  1  single clock; all state updates on posedge Clock.
REQ-004 Reset  input  1  reset, synchronous and active-high.
REQ-005 Run  input  1  start request, sampled only in IDLE.
REQ-006 DIN  input  DATA_W  memory read data, valid only when Ack=1.
REQ-007 Ack  input  1  memory completion; Ack=1 while Req=1 completes the access.
REQ-008 Req  output  1  memory request, registered, held until Ack.
REQ-009 W  output  1  write enable, registered; valid only while Req=1.
REQ-010 ADDR  output  ADDR_W  memory address, registered.
REQ-011 DOUT  output  DATA_W  memory write data, registered.
REQ-012 Done  output  1  high for exactly the final cycle of each instruction.

Function
REQ-013 Eight DATA_W registers R0-R7; R7 SHALL be the PC; instruction word is DIN[15:0]: III[15:13] M[12] rX/cond[11:9] D[8:0] rY[2:0].
REQ-014 Opcodes: 000 mv, 001 mvt, 010 add, 011 sub, 100 ld, 101 st, 110 and, 111 b; M=1 selects immediate D, zero-extended to DATA_W.
REQ-015 mvt SHALL load D[7:0] into bits [DATA_W-1:DATA_W-8], lower bits zero.
REQ-016 States IDLE, FETCH, EX1, EX2, EX3, MEM; reset state IDLE.
REQ-017 IDLE: Run=1 -> ADDR<=PC[ADDR_W-1:0], Req<=1, W<=0, PC<=PC+1, go FETCH; Run=0 -> stay.
REQ-018 FETCH: hold Req; on Ack IR<=DIN[15:0], Req<=0, go EX1; no Ack -> stay, no timeout.
REQ-019 EX1: mv/mvt -> rX<=operand, Done, go IDLE; add/sub/and -> A<=rX, go EX2; ld/st -> ADDR<=rY, Req<=1, W<=(st), DOUT<=rX, go MEM; b -> EX1 resolves, Done, go IDLE.
REQ-020 EX2: G<=A op operand, flags updated, go EX3; EX3: rX<=G, Done, go IDLE.
REQ-021 MEM: hold Req/W/ADDR/DOUT; on Ack: ld -> rX<=DIN, st -> no register write; Req<=0, W<=0, Done, go IDLE.
REQ-022 Flags z,n,c updated only in EX2: z=(result==0), n=result[DATA_W-1]; add c=carry out; sub c=1 iff A<operand unsigned (borrow); and c=0.
REQ-023 Arithmetic SHALL wrap modulo 2^DATA_W; PC increment SHALL wrap likewise.
REQ-024 b: cond 000 always, 001 z, 010 !z, 011 !c, 100 c, 101 !n, 110 n; taken -> PC<=PC+sign-extended D[8:0] (PC already incremented).
REQ-025 Any write to R7 (mv, ld, arithmetic) SHALL act as a jump; no PC increment that cycle.
REQ-026 Ack outside FETCH/MEM, or while Req=0, SHALL be ignored.
REQ-027 Latency with Ack in first Req cycle: mv/mvt/b 3 cycles Run-to-Done; add/sub/and 5; ld/st 4; each extra Ack wait adds 1.

Reset
REQ-028 Reset=1 at posedge: state IDLE, R0-R7=0, A=G=0, z=n=c=0, Req=W=Done=0, ADDR=DOUT=0, IR=0.
REQ-029 Reset mid-operation SHALL abort immediately: Req and W low the next cycle; no register or flag write for the aborted instruction; a late Ack SHALL be ignored.

Configuration
REQ-030 Macro PROC_BL_EN defined: cond 111 = bl, unconditional; R6<=PC, then PC<=PC+sign-extended D; both take effect in EX1 on the same edge.
REQ-031 PROC_BL_EN undefined: cond 111 is a no-op branch; Done still pulses in EX1 and R6 is unchanged.

Verification
REQ-032 Reset, mem[0]=mv R1,#5 (0x1205), Run=1, Ack immediate -> R1=5, Done in cycle 3, PC=1.
REQ-033 R2=0xFFFF, add R2,#1 -> R2=0, z=1, c=1, n=0; then bne -> not taken; beq -> taken.
REQ-034 st R3,[R4] with R3=0xABCD, R4=0x10, Ack delayed 3 cycles -> Req/W/ADDR=0x10/DOUT=0xABCD held 4 cycles, Done on Ack cycle.
REQ-035 b with D=0x1FE (-2) at PC=5 -> PC=4; PC=0xFFFF then fetch -> PC wraps to 0.
REQ-036 Reset asserted in MEM during ld with Ack 2 cycles later -> Req=0 next cycle, rX unchanged, state IDLE.
REQ-037 PROC_BL_EN defined, bl D=4 at PC=2 -> R6=3, PC=7; undefined -> R6 unchanged, PC=3.
